// File: rtl/pc.sv
// Program-counter register for the instruction-fetch stage.
// Holds the address of the instruction being fetched and loads the
// upstream-computed next PC on each enabled rising clock edge.
//
// Ports:
//   i_clk     system clock, rising-edge active
//   i_reset   asynchronous active-high reset; forces o_pc to RESET_PC
//   i_enable  load enable (1 = load i_pc at next edge, 0 = hold/stall)
//   i_pc      next-PC value, loaded bit-for-bit
//   o_pc      current PC, driven directly from the register
module pc #(
    parameter int unsigned     PC_SZ    = 32,
    parameter logic [PC_SZ-1:0] RESET_PC = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [PC_SZ-1:0] i_pc,
    output logic [PC_SZ-1:0] o_pc
);

    logic [PC_SZ-1:0] pc_q;

    // PC register: reset dominates, a deasserted enable freezes fetch
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc_q <= RESET_PC;
        end else if (i_enable) begin
            pc_q <= i_pc;
        end
    end

    assign o_pc = pc_q;

endmodule

// File: tb/tb_pc.sv
// Self-checking testbench for pc: directed scenarios followed by random
// stimulus, checked every cycle against a behavioural model of the PC.
module tb_pc;

    localparam int unsigned PC_SZ = 32;
    localparam logic [PC_SZ-1:0] RST_VAL = '0;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_enable;
    logic [PC_SZ-1:0] i_pc;
    logic [PC_SZ-1:0] o_pc;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [PC_SZ-1:0] exp_pc = '0;
    bit               model_valid = 1'b0;

    pc #(
        .PC_SZ    (PC_SZ),
        .RESET_PC (RST_VAL)
    ) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_pc     (i_pc),
        .o_pc     (o_pc)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [PC_SZ-1:0] act,
                         input logic [PC_SZ-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: o_pc=0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the PC must hold after each rising edge, then compare.
    always @(posedge i_clk) begin
        if (model_valid) begin
            if (i_reset)
                exp_pc = RST_VAL;
            else if (i_enable)
                exp_pc = i_pc;
            #1;
            check("cycle", o_pc, exp_pc);
        end
    end

    // Inputs change on the falling edge, well clear of the sampling edge.
    task automatic drive(input logic r, input logic e, input logic [PC_SZ-1:0] p);
        @(negedge i_clk);
        i_reset  = r;
        i_enable = e;
        i_pc     = p;
    endtask

    task automatic wait_edge();
        @(posedge i_clk);
        #2;
    endtask

    // Reset pulse entirely between two rising edges.
    task automatic async_pulse(input logic e, input logic [PC_SZ-1:0] p);
        @(negedge i_clk);
        i_reset  = 1'b1;
        i_enable = e;
        i_pc     = p;
        #1;
        exp_pc = RST_VAL;
        check("async_reset", o_pc, RST_VAL);
        #1;
        i_reset = 1'b0;
    endtask

    initial begin
        i_reset  = 1'b1;
        i_enable = 1'b1;
        i_pc     = 32'h10;
        #1;
        check("reset_t0", o_pc, 32'h0);
        model_valid = 1'b1;

        // Reset held two cycles with enable and a non-zero i_pc
        drive(1'b1, 1'b1, 32'h10);
        drive(1'b1, 1'b1, 32'h10);
        wait_edge();
        check("reset_held", o_pc, 32'h0);

        // Sequential load 4..40
        for (int k = 1; k <= 10; k++) begin
            drive(1'b0, 1'b1, PC_SZ'(4 * k));
            wait_edge();
            check("seq_load", o_pc, PC_SZ'(4 * k));
        end
        check("seq_end", o_pc, 32'd40);

        // Stall two cycles while i_pc changes, then re-enable
        drive(1'b0, 1'b0, 32'd44);
        wait_edge();
        drive(1'b0, 1'b0, 32'd48);
        wait_edge();
        check("stall_hold", o_pc, 32'd40);
        drive(1'b0, 1'b1, 32'd48);
        wait_edge();
        check("reenable", o_pc, 32'd48);

        // Async reset mid-run from 0x20
        drive(1'b0, 1'b1, 32'h20);
        wait_edge();
        check("pre_async", o_pc, 32'h20);
        async_pulse(1'b1, 32'd4);
        wait_edge();
        check("post_async_load", o_pc, 32'd4);

        // Reset and enable on the same edge
        drive(1'b1, 1'b1, 32'h100);
        wait_edge();
        check("reset_vs_enable", o_pc, 32'h0);

        // Boundary values, loaded unmasked
        drive(1'b0, 1'b1, 32'hFFFF_FFFF);
        wait_edge();
        check("max_val", o_pc, 32'hFFFF_FFFF);
        drive(1'b0, 1'b1, 32'hFFFF_FFFD);
        wait_edge();
        check("unaligned_val", o_pc, 32'hFFFF_FFFD);

        // Random: stalls, loads, synchronous-looking and mid-cycle resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 24) == 0)
                async_pulse(1'($urandom), $urandom);
            else
                drive(($urandom_range(0, 15) == 0), 1'($urandom), $urandom);
        end

        wait_edge();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc.md
# pc

Program-counter register for the instruction-fetch stage of the pipelined processor. It holds the address of the instruction currently being fetched and presents it on `o_pc` every cycle. On each enabled rising clock edge it loads the next-PC value computed upstream (PC+4, branch or jump target). It holds its value when the enable is deasserted, which is how hazard-detection stalls freeze fetch.

## Interface
- `PC_SZ`, default 32: width of the program counter in bits.
- `RESET_PC`, default 0 (`PC_SZ` bits): value loaded into the PC on reset.

- `i_clk`  input  1  system clock; all state changes on the rising edge.
- `i_reset`  input  1  reset, asynchronous and active-high.
- `i_enable`  input  1  load enable; 1 = load `i_pc` at the next rising edge, 0 = hold. The parent ANDs run-enable with the inverted hazard-stall signal before driving this port.
- `i_pc`  input  `PC_SZ`  next-PC value to be loaded.
- `o_pc`  output  `PC_SZ`  current PC, driven directly from the register.

## Operation
- Single `PC_SZ`-bit register; `o_pc` is the register output with no combinational path from any input.
- Reset:
  - `i_reset` = 1 forces the register to `RESET_PC` immediately, without waiting for a clock edge.
  - It stays at `RESET_PC` for as long as reset is held.
- Load: at a rising `i_clk` edge with `i_reset` = 0 and `i_enable` = 1, the register takes `i_pc`.
- Hold: at a rising edge with `i_enable` = 0, the register keeps its value, regardless of `i_pc`.
- Priority: reset > enable > hold.
- Arithmetic:
  - No arithmetic inside the block; incrementing is done upstream.
  - `i_pc` is loaded bit-for-bit: no alignment masking, no truncation, no wrap handling.
  - All `PC_SZ` bits are stored, so any value 0 to 2^`PC_SZ`−1 is legal.
- No X propagation from the register after reset: every bit has a defined reset value.

## Timing
- Load latency: one clock. A value presented on `i_pc` before rising edge N appears on `o_pc` just after edge N (clock-to-q only).
- Reset assertion: `o_pc` = `RESET_PC` within the same timestep, with no clock required.
- Reset deassertion: the first load happens on the first rising edge at which `i_reset` = 0 and `i_enable` = 1.
- Reset mid-operation: asserting reset between edges clears `o_pc` immediately. Any pending load is discarded.
- Simultaneous events:
  - Reset and enable on the same edge: reset wins.
  - Enable falling in the same cycle as an `i_pc` change: the register holds the old value.
- Stall:
  - While `i_enable` = 0 for K cycles, `o_pc` is constant for K edges.
  - On re-enable, the next edge loads the `i_pc` present at that edge; no stale value is replayed.
- `i_enable` and `i_pc` must meet setup/hold to `i_clk`. No handshake and no internal pipelining.

## Test plan
- Reset: hold `i_reset` = 1 for 2 cycles with `i_pc` = 0x10 and `i_enable` = 1 -> `o_pc` = 0x00000000 throughout.
- Sequential load: release reset, drive `i_pc` = 4, 8, … 40, one value per cycle, `i_enable` = 1 -> `o_pc` shows 4, 8, … 40, each one edge after it is presented.
- Stall: with `o_pc` = 40, drop `i_enable` to 0 and change `i_pc` to 44 and then 48 over 2 cycles -> `o_pc` stays 40. Re-enable with `i_pc` = 48 -> `o_pc` = 48 after the next edge.
- Async reset mid-run: with `o_pc` = 0x20, pulse `i_reset` high between clock edges -> `o_pc` = 0 before the next edge. After release, `i_pc` = 4 -> `o_pc` = 4 after one edge.
- Reset vs. enable: assert `i_reset` = 1 and `i_enable` = 1 with `i_pc` = 0x100 across a rising edge -> `o_pc` = 0.
- Boundary values: load `i_pc` = 0xFFFFFFFF, then 0xFFFFFFFD -> `o_pc` shows exactly those values, unmasked.
